// File: rtl/ff_bank_arbiter_pkg.sv
// Shared constants and helper functions for the ff_bank_arbiter slice.
package ff_bank_pkg;

    localparam int WRCNT_WIDTH = 16;
    localparam logic [WRCNT_WIDTH-1:0] WRCNT_MAX = {WRCNT_WIDTH{1'b1}};

    // Packed request vectors are widened to PACK_W before slicing; MAX_REQ bounds one-hot inputs.
    localparam int PACK_W  = 256;
    localparam int MAX_REQ = 8;

    function automatic logic [31:0] get_slice(input logic [PACK_W-1:0] vec,
                                              input int unsigned idx,
                                              input int unsigned width);
        logic [PACK_W-1:0] shifted;
        shifted = vec >> (idx * width);
        return shifted[31:0] & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] get_addr(input logic [PACK_W-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned addrWidth);
        return get_slice(vec, idx, addrWidth);
    endfunction

    function automatic logic [31:0] get_data(input logic [PACK_W-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned dataWidth);
        return get_slice(vec, idx, dataWidth);
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// Round-robin picker: rotate requests by the pointer, take the lowest set bit, rotate back.
module rr_pick
    import ff_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] Req_SI,
    input  logic [PTR_W-1:0]   Ptr_DI,
    output logic [NUM_REQ-1:0] Gnt_SO,
    output logic [PTR_W-1:0]   Idx_DO,
    output logic               Valid_SO
);

    logic [2*NUM_REQ-1:0] reqDbl;
    logic [NUM_REQ-1:0]   reqRot;
    logic [NUM_REQ-1:0]   lowest;
    logic [PTR_W-1:0]     offs;
    logic [PTR_W:0]       sum;

    always_comb begin
        reqDbl   = {Req_SI, Req_SI} >> Ptr_DI;
        reqRot   = reqDbl[NUM_REQ-1:0];
        lowest   = reqRot & (~reqRot + 1'b1);
        offs     = PTR_W'(onehot_to_idx(MAX_REQ'(lowest)));
        Valid_SO = |Req_SI;
        // Modular add back to the un-rotated index; both operands are below NUM_REQ.
        sum      = {1'b0, Ptr_DI} + {1'b0, offs};
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
        Idx_DO   = sum[PTR_W-1:0];
        Gnt_SO   = '0;
        if (Valid_SO) Gnt_SO[Idx_DO] = 1'b1;
    end

endmodule

// File: rtl/ff_bank_arbiter_word.sv
// Standard write-enable register word with asynchronous active-low clear.
module ff_bank_word #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  We_SI,
    input  logic [DATA_WIDTH-1:0] D_DI,
    output logic [DATA_WIDTH-1:0] Q_DO
);

    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)   word_q <= '0;
        else if (We_SI) word_q <= D_DI;
    end

    assign Q_DO = word_q;

endmodule

// File: rtl/ff_bank_arbiter.sv
// Round-robin write arbiter driving a shared register bank, with read port and write counter.
// Optional hold-priority lock input is enabled by defining FF_BANK_ARB_LOCK_EN.
module ff_bank_arbiter
    import ff_bank_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 10
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic [NUM_REQ-1:0]            Req_SI,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] Addr_DI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_DI,
`ifdef FF_BANK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            Lock_SI,
`endif
    output logic [NUM_REQ-1:0]            Gnt_SO,
    input  logic [ADDR_WIDTH-1:0]         RdAddr_DI,
    output logic [DATA_WIDTH-1:0]         RdData_DO,
    output logic [WRCNT_WIDTH-1:0]        WrCnt_DO
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [WRCNT_WIDTH-1:0] wrCnt_q, wrCnt_d;
    logic [NUM_REQ-1:0]     gnt;
    logic [PTR_W-1:0]       gIdx;
    logic                   gValid;
    logic                   hold;
    logic [ADDR_WIDTH-1:0]  addrG;
    logic [DATA_WIDTH-1:0]  dataG;
    logic                   commit;
    logic [NUM_REGS-1:0]    we;
    logic [DATA_WIDTH-1:0]  words [NUM_REGS];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .Req_SI   (Req_SI),
        .Ptr_DI   (ptr_q),
        .Gnt_SO   (gnt),
        .Idx_DO   (gIdx),
        .Valid_SO (gValid)
    );

    assign Gnt_SO = gnt;

    always_comb begin
        addrG  = ADDR_WIDTH'(get_addr(PACK_W'(Addr_DI), 32'(gIdx), ADDR_WIDTH));
        dataG  = DATA_WIDTH'(get_data(PACK_W'(Data_DI), 32'(gIdx), DATA_WIDTH));
        // Out-of-range grants still rotate the pointer but never reach the bank or the counter.
        commit = gValid && (32'(addrG) < 32'(NUM_REGS));
        we     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            we[r] = commit && (addrG == ADDR_WIDTH'(r));
        end
`ifdef FF_BANK_ARB_LOCK_EN
        hold = Lock_SI[gIdx];
`else
        hold = 1'b0;
`endif
        ptr_d = ptr_q;
        if (gValid) begin
            if (hold)                           ptr_d = gIdx;
            else if (gIdx == PTR_W'(NUM_REQ-1)) ptr_d = '0;
            else                                ptr_d = gIdx + 1'b1;
        end
        wrCnt_d = wrCnt_q;
        if (commit && (wrCnt_q != WRCNT_MAX)) wrCnt_d = wrCnt_q + 1'b1;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr_q   <= '0;
            wrCnt_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wrCnt_q <= wrCnt_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_word
        ff_bank_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .Clk_CI  (Clk_CI),
            .Rst_RBI (Rst_RBI),
            .We_SI   (we[r]),
            .D_DI    (dataG),
            .Q_DO    (words[r])
        );
    end

    always_comb begin
        RdData_DO = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (RdAddr_DI == ADDR_WIDTH'(r)) RdData_DO = words[r];
        end
    end

    assign WrCnt_DO = wrCnt_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Scoreboard bench for ff_bank_arbiter: a spec-level model queues expected outputs, a monitor compares.
module tb_ff_bank_arbiter;

    localparam int NR    = 4;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int DW    = 10;
`ifdef FF_BANK_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             Clk_CI = 1'b0;
    logic             Rst_RBI;
    logic [NR-1:0]    Req_SI;
    logic [NR-1:0]    Lock_SI;
    logic [NR*AW-1:0] Addr_DI;
    logic [NR*DW-1:0] Data_DI;
    logic [AW-1:0]    RdAddr_DI;
    logic [NR-1:0]    Gnt_SO;
    logic [DW-1:0]    RdData_DO;
    logic [15:0]      WrCnt_DO;

    ff_bank_arbiter #(
        .NUM_REQ    (NR),
        .NUM_REGS   (NREGS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .Req_SI    (Req_SI),
        .Addr_DI   (Addr_DI),
        .Data_DI   (Data_DI),
`ifdef FF_BANK_ARB_LOCK_EN
        .Lock_SI   (Lock_SI),
`endif
        .Gnt_SO    (Gnt_SO),
        .RdAddr_DI (RdAddr_DI),
        .RdData_DO (RdData_DO),
        .WrCnt_DO  (WrCnt_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    typedef struct {
        logic [NR-1:0] gnt;
        logic [DW-1:0] rd;
        logic [15:0]   cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mBank [NREGS];
    int            mPtr;
    int            mCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    always @(negedge Clk_CI) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("gnt",   32'(Gnt_SO),    32'(e.gnt));
            checkOutput("rdata", 32'(RdData_DO), 32'(e.rd));
            checkOutput("wrcnt", 32'(WrCnt_DO),  32'(e.cnt));
        end
    end

    // Drives one cycle, queues the model's expected outputs, then applies the model's edge update.
    task automatic applyStimulus(input logic rstN, input logic [NR-1:0] req, input logic [NR-1:0] lck,
                                 input logic [NR*AW-1:0] addr, input logic [NR*DW-1:0] data,
                                 input logic [AW-1:0] rdA);
        exp_t e;
        int   g;
        int   a;
        Rst_RBI   = rstN;
        Req_SI    = req;
        Lock_SI   = lck;
        Addr_DI   = addr;
        Data_DI   = data;
        RdAddr_DI = rdA;
        if (!rstN) begin
            mPtr = 0;
            mCnt = 0;
            for (int i = 0; i < NREGS; i++) mBank[i] = '0;
        end
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (mPtr + k) % NR;
            if (g < 0 && req[idx]) g = idx;
        end
        e.gnt = '0;
        if (g >= 0) e.gnt[g] = 1'b1;
        e.rd = '0;
        if (int'(rdA) < NREGS) e.rd = mBank[int'(rdA)];
        e.cnt = 16'(mCnt);
        expQ.push_back(e);
        @(posedge Clk_CI);
        #1;
        if (rstN && g >= 0) begin
            a = int'(addr[g*AW +: AW]);
            if (a < NREGS) begin
                mBank[a] = data[g*DW +: DW];
                if (mCnt < 65535) mCnt++;
            end
            mPtr = (LOCK_EN && lck[g]) ? g : (g + 1) % NR;
        end
    endtask

    initial begin
        logic [NR*AW-1:0] av;
        logic [NR*DW-1:0] dv;
        logic [63:0]      rnd;
        Rst_RBI   = 1'b0;
        Req_SI    = '0;
        Lock_SI   = '0;
        Addr_DI   = '0;
        Data_DI   = '0;
        RdAddr_DI = '0;
        mPtr      = 0;
        mCnt      = 0;
        for (int i = 0; i < NREGS; i++) mBank[i] = '0;
        @(posedge Clk_CI);
        #1;

        applyStimulus(1'b0, 4'b0000, '0, '0, '0, 3'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b0000, '0, '0, '0, 3'(i));

        av = '0; dv = '0;
        av[1*AW +: AW] = 3'd3;
        dv[1*DW +: DW] = 10'h155;
        applyStimulus(1'b1, 4'b0010, '0, av, dv, 3'd3);
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, 3'd3);

        applyStimulus(1'b0, 4'b0000, '0, '0, '0, 3'd3);
        for (int i = 0; i < NR; i++) begin
            av[i*AW +: AW] = 3'(i + 1);
            dv[i*DW +: DW] = 10'(10'h2A0 + i);
        end
        for (int c = 0; c < 8; c++) applyStimulus(1'b1, 4'b1111, '0, av, dv, 3'(c % NREGS));
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, 3'd4);

        av = '0; dv = '0;
        av[0*AW +: AW] = 3'd5; dv[0*DW +: DW] = 10'h0AA;
        av[2*AW +: AW] = 3'd5; dv[2*DW +: DW] = 10'h3C3;
        applyStimulus(1'b1, 4'b0101, '0, av, dv, 3'd5);
        applyStimulus(1'b1, 4'b0100, '0, av, dv, 3'd5);
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, 3'd5);

        av = '0; dv = '0;
        av[3*AW +: AW] = 3'd7; dv[3*DW +: DW] = 10'h1FF;
        applyStimulus(1'b1, 4'b1000, '0, av, dv, 3'd7);
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, 3'd7);

        applyStimulus(1'b0, 4'b0000, '0, '0, '0, 3'd0);
        av = {3'd3, 3'd2, 3'd1, 3'd0};
        dv = {10'd4, 10'd3, 10'd2, 10'd1};
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'b0011, (c < 3) ? 4'b0001 : 4'b0000, av, dv, 3'(c % 2));

        applyStimulus(1'b1, 4'b0110, '0, av, dv, 3'd1);
        applyStimulus(1'b0, 4'b1111, '0, av, dv, 3'd1);
        applyStimulus(1'b1, 4'b1111, '0, av, dv, 3'd0);

        for (int c = 0; c < 3000; c++) begin
            rnd = {$urandom(), $urandom()};
            dv  = rnd[NR*DW-1:0];
            rnd = {$urandom(), $urandom()};
            av  = rnd[NR*AW-1:0];
            applyStimulus(($urandom_range(0, 63) != 0), NR'($urandom()), NR'($urandom()),
                          av, dv, AW'($urandom()));
        end

        @(negedge Clk_CI);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

Round-robin write arbiter and controller for a shared bank of write-enabled, async-reset register words. It accepts write requests from up to NUM_REQ requesters, grants one per cycle, and drives the per-word write enables of the bank. It also provides one combinational read port and a saturating count of committed writes. It sits between the requesting datapath blocks and the shared configuration/state register bank.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of register words in the bank
- ADDR_WIDTH, 3, word address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS
- DATA_WIDTH, 10, bits per register word
- Clk_CI  in  1  clock, rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- Req_SI  in  NUM_REQ  write request, one bit per requester
- Addr_DI  in  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i uses slice i
- Data_DI  in  NUM_REQ*DATA_WIDTH  packed write data; requester i uses slice i
- Lock_SI  in  NUM_REQ  hold-priority request; present only with FF_BANK_ARB_LOCK_EN
- Gnt_SO  out  NUM_REQ  one-hot grant, combinational
- RdAddr_DI  in  ADDR_WIDTH  read address
- RdData_DO  out  DATA_WIDTH  read data, combinational from the bank
- WrCnt_DO  out  16  saturating count of committed writes

## Operation
- State: round-robin pointer Ptr (index 0..NUM_REQ-1), the bank (NUM_REGS x DATA_WIDTH), and WrCnt.
- Arbitration:
  - Search Req_SI starting at index Ptr, ascending with wrap.
  - The first set bit wins and gets Gnt_SO = one-hot of the winner.
  - If no requests are set, Gnt_SO = 0.
  - At most one grant per cycle.
- Commit:
  - With a grant to requester g, on the rising edge ending the cycle, word Addr_DI[g] <= Data_DI[g].
  - Only that word's write enable is asserted; all other words hold.
- Pointer update on a granted cycle: Ptr <= (g+1) mod NUM_REQ. No change when there is no grant.
- Handshake:
  - The requester holds Req, Addr and Data stable until it sees Gnt high. The write is complete at that edge.
  - If Req stays high after the grant, it is a new write request.
  - Dropping Req before the grant withdraws the request without effect.
- Out-of-range address (Addr >= NUM_REGS):
  - The grant is still issued and Ptr still advances.
  - The write is dropped and WrCnt is not incremented.
- WrCnt increments by 1 per committed write and saturates at 16'hFFFF.
- Read:
  - RdData_DO = bank[RdAddr_DI]; returns 0 for an out-of-range address.
  - Read-during-write to the same word returns the old value in that cycle and the new value from the next cycle.
- Reset (Rst_RBI low, any time including mid-request): all words = 0, Ptr = 0, WrCnt = 0. While reset is asserted, no commit occurs. Gnt_SO follows Req_SI with Ptr = 0, but the grant has no effect.

## Timing
- Grant latency: 0 cycles (combinational from Req_SI and Ptr).
- Write latency: data is visible on RdData_DO 1 cycle after the grant cycle.
- Reset values: Gnt_SO = f(Req_SI, Ptr = 0), RdData_DO = 0, WrCnt_DO = 0.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles when lock is compiled out.
- All state changes on the rising edge of Clk_CI, except the asynchronous reset.

## Configuration
- FF_BANK_ARB_LOCK_EN defined:
  - The Lock_SI port exists.
  - In a granted cycle where Lock_SI[g] = 1, Ptr <= g (not g+1), so g keeps top priority next cycle.
  - Lock has no effect in cycles where that requester is not granted.
  - Starvation while a lock is held is accepted by design.
- FF_BANK_ARB_LOCK_EN undefined: no Lock_SI port; pure round-robin as above.

## Structure
- Package ff_bank_pkg:
  - WRCNT_WIDTH = 16 and WRCNT_MAX.
  - Helper functions for packed-slice extraction (addr/data of requester i).
  - Function onehot_to_idx.
- Sub-module rr_pick:
  - Combinational rotate, priority-encode, un-rotate.
  - Inputs Req and Ptr; outputs one-hot Gnt, index g, and a valid flag.
- Bank: NUM_REGS instances of the team's standard write-enable register word (DATA_WIDTH), with write enable = grant-valid & address-decode.

## Test plan
- Reset then idle → Gnt_SO = 0, WrCnt_DO = 0, RdData_DO = 0 for all addresses 0..7.
- Req_SI = 4'b0010, Addr1 = 3, Data1 = 10'h155 for one cycle → Gnt_SO = 4'b0010; next cycle RdData_DO(3) = 10'h155, WrCnt_DO = 1.
- Req_SI = 4'b1111 held, distinct addresses, for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; WrCnt_DO = 8.
- Req from requesters 0 and 2, both to address 5 → requester 0 wins and writes first; requester 2 writes next cycle; RdData_DO(5) = Data2.
- Addr = 7 with NUM_REGS = 6 → grant issued, bank unchanged, WrCnt_DO unchanged, RdData_DO(7) = 0.
- With FF_BANK_ARB_LOCK_EN, Req = 4'b0011 and Lock0 = 1 for 3 cycles, then Lock0 = 0 → grants 0,0,0,0,1. Also: Rst_RBI pulsed mid-stream → all words 0, WrCnt_DO 0, next grant to requester 0.
